high_score_keeper: RTL and testbench

//  Downstream of the LED/score stage and the countdown timer. Keeps a small
//  per-user best-score table keyed by the logged-in user ID and an overall

---
 rtl/high_score_keeper_pkg.sv | 16 +
 rtl/hs_slot_table.sv | 57 +++++
 rtl/high_score_keeper.sv | 235 +++++++++++++++++++++++
 tb/tb_high_score_keeper.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/high_score_keeper_pkg.sv
// high_score_keeper_pkg: shared parameter defaults and FSM state encoding for the high score keeper
package high_score_keeper_pkg;
  localparam int USER_W_DEF = 4;
  localparam int SCORE_W_DEF = 7;
  localparam int NUM_SLOTS_DEF = 4;
  localparam int SHOW_TICKS_DEF = 30;
  localparam int BLINK_TICKS_DEF = 5;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_READY,
    S_PLAYING,
    S_UPDATE,
    S_SHOW
  } state_t;
endpackage

// File: rtl/hs_slot_table.sv
// hs_slot_table: per-user {valid, id, best} register array with a scan read port and one write port
module hs_slot_table
  import high_score_keeper_pkg::*;
#(
  parameter int NUM_SLOTS = NUM_SLOTS_DEF,
  parameter int USER_W = USER_W_DEF,
  parameter int SCORE_W = SCORE_W_DEF,
  parameter int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
)(
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SLOT_W-1:0]            rd_idx,
  output logic                         rd_valid,
  output logic [USER_W-1:0]            rd_id,
  input  logic                         we,
  input  logic [SLOT_W-1:0]            wr_idx,
  input  logic                         wr_valid,
  input  logic [USER_W-1:0]            wr_id,
  input  logic [SCORE_W-1:0]           wr_best,
  output logic [NUM_SLOTS-1:0]         valid,
  output logic [NUM_SLOTS*SCORE_W-1:0] bests
);
  logic [NUM_SLOTS-1:0] valid_q, valid_d;
  logic [USER_W-1:0] id_q [NUM_SLOTS];
  logic [USER_W-1:0] id_d [NUM_SLOTS];
  logic [SCORE_W-1:0] best_q [NUM_SLOTS];
  logic [SCORE_W-1:0] best_d [NUM_SLOTS];
  always_comb begin
    valid_d = valid_q;
    id_d = id_q;
    best_d = best_q;
    if (we) begin
      valid_d[wr_idx] = wr_valid;
      id_d[wr_idx] = wr_id;
      best_d[wr_idx] = wr_best;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        id_q[i] <= '0;
        best_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      id_q <= id_d;
      best_q <= best_d;
    end
  end
  assign rd_valid = valid_q[rd_idx];
  assign rd_id = id_q[rd_idx];
  assign valid = valid_q;
  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_bests
    assign bests[g*SCORE_W +: SCORE_W] = best_q[g];
  end
endmodule

// File: rtl/high_score_keeper.sv
// high_score_keeper: per-user best-score table with overall best, record flag and timed best-score display
module high_score_keeper
  import high_score_keeper_pkg::*;
#(
  parameter int USER_W = USER_W_DEF,
  parameter int SCORE_W = SCORE_W_DEF,
  parameter int NUM_SLOTS = NUM_SLOTS_DEF,
  parameter int SHOW_TICKS = SHOW_TICKS_DEF,
  parameter int BLINK_TICKS = BLINK_TICKS_DEF
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               user_load,
  input  logic [USER_W-1:0]  user_id,
  input  logic               game_start,
  input  logic               game_stop,
  input  logic [SCORE_W-1:0] score,
  input  logic               tick_100ms,
  output logic               busy,
  output logic [SCORE_W-1:0] best_user_score,
  output logic [SCORE_W-1:0] best_overall,
  output logic [USER_W-1:0]  best_overall_user,
  output logic               new_record,
  output logic               record_led,
  output logic               disp_sel
);
  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int IDX_W = SLOT_W + 1;
  localparam int TICK_W = $clog2(SHOW_TICKS + 1);
  localparam int BLINK_W = $clog2(BLINK_TICKS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS);
  localparam logic [TICK_W-1:0] SHOW_LAST = TICK_W'(SHOW_TICKS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);
  state_t state_q, state_d;
  logic [USER_W-1:0] uid_q, uid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SLOT_W-1:0] cur_q, cur_d;
  logic user_valid_q, user_valid_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic start_prev_q, start_prev_d;
  logic new_record_q, new_record_d;
  logic [SCORE_W-1:0] best_overall_q, best_overall_d;
  logic [USER_W-1:0] best_overall_user_q, best_overall_user_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [BLINK_W-1:0] blink_q, blink_d;
  logic led_q, led_d;
  logic rd_valid;
  logic [USER_W-1:0] rd_id;
  logic tbl_we;
  logic [SLOT_W-1:0] wr_idx;
  logic [SCORE_W-1:0] wr_best;
  logic [NUM_SLOTS-1:0] slot_valid;
  logic [NUM_SLOTS*SCORE_W-1:0] slot_bests;
  logic [SCORE_W-1:0] slot_best [NUM_SLOTS];
  logic inv_found;
  logic [SLOT_W-1:0] inv_idx, min_idx, victim;
  logic [SCORE_W-1:0] min_best;
  logic start_rise;
  hs_slot_table #(
    .NUM_SLOTS(NUM_SLOTS),
    .USER_W(USER_W),
    .SCORE_W(SCORE_W),
    .SLOT_W(SLOT_W)
  ) u_table (
    .clk(clk),
    .rst(rst),
    .rd_idx(idx_q[SLOT_W-1:0]),
    .rd_valid(rd_valid),
    .rd_id(rd_id),
    .we(tbl_we),
    .wr_idx(wr_idx),
    .wr_valid(1'b1),
    .wr_id(uid_q),
    .wr_best(wr_best),
    .valid(slot_valid),
    .bests(slot_bests)
  );
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) slot_best[i] = slot_bests[i*SCORE_W +: SCORE_W];
  end
  always_comb begin
    inv_found = 1'b0;
    inv_idx = '0;
    min_idx = '0;
    min_best = slot_best[0];
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!inv_found && !slot_valid[i]) begin
        inv_found = 1'b1;
        inv_idx = SLOT_W'(i);
      end
      if (slot_best[i] < min_best) begin
        min_best = slot_best[i];
        min_idx = SLOT_W'(i);
      end
    end
    victim = inv_found ? inv_idx : min_idx;
  end
  assign start_rise = game_start && !start_prev_q;
  always_comb begin
    state_d = state_q;
    uid_d = uid_q;
    idx_d = idx_q;
    cur_d = cur_q;
    user_valid_d = user_valid_q;
    score_d = score_q;
    start_prev_d = game_start;
    new_record_d = new_record_q;
    best_overall_d = best_overall_q;
    best_overall_user_d = best_overall_user_q;
    tick_d = tick_q;
    blink_d = blink_q;
    led_d = led_q;
    tbl_we = 1'b0;
    wr_idx = cur_q;
    wr_best = score_q;
    case (state_q)
      S_IDLE: if (user_load) begin
        uid_d = user_id;
        idx_d = '0;
        user_valid_d = 1'b0;
        state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (idx_q == LAST_IDX) begin
          tbl_we = 1'b1;
          wr_idx = victim;
          wr_best = '0;
          cur_d = victim;
          user_valid_d = 1'b1;
          state_d = S_READY;
        end else if (rd_valid && rd_id == uid_q) begin
          cur_d = idx_q[SLOT_W-1:0];
          user_valid_d = 1'b1;
          state_d = S_READY;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_READY: begin
        if (start_rise) begin
          new_record_d = 1'b0;
          state_d = S_PLAYING;
        end else if (user_load) begin
          uid_d = user_id;
          idx_d = '0;
          user_valid_d = 1'b0;
          state_d = S_LOOKUP;
        end
      end
      S_PLAYING: begin
        if (game_stop) begin
          score_d = score;
          state_d = S_UPDATE;
        end else if (!game_start) begin
          state_d = S_READY;
        end
      end
      S_UPDATE: begin
        if (score_q > slot_best[cur_q]) begin
          tbl_we = 1'b1;
          new_record_d = 1'b1;
        end
        if (score_q > best_overall_q) begin
          best_overall_d = score_q;
          best_overall_user_d = uid_q;
        end
        tick_d = '0;
        blink_d = '0;
        led_d = 1'b0;
        state_d = S_SHOW;
      end
      S_SHOW: begin
        if (start_rise) begin
          new_record_d = 1'b0;
          led_d = 1'b0;
          state_d = S_PLAYING;
        end else if (user_load) begin
          uid_d = user_id;
          idx_d = '0;
          user_valid_d = 1'b0;
          led_d = 1'b0;
          state_d = S_LOOKUP;
        end else if (tick_100ms) begin
          if (tick_q == SHOW_LAST) begin
            led_d = 1'b0;
            state_d = S_READY;
          end else begin
            tick_d = tick_q + 1'b1;
            blink_d = (blink_q == BLINK_LAST) ? '0 : blink_q + 1'b1;
            led_d = (blink_q == BLINK_LAST) ? (new_record_q && !led_q) : led_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      uid_q <= '0;
      idx_q <= '0;
      cur_q <= '0;
      user_valid_q <= 1'b0;
      score_q <= '0;
      start_prev_q <= 1'b0;
      new_record_q <= 1'b0;
      best_overall_q <= '0;
      best_overall_user_q <= '0;
      tick_q <= '0;
      blink_q <= '0;
      led_q <= 1'b0;
    end else begin
      state_q <= state_d;
      uid_q <= uid_d;
      idx_q <= idx_d;
      cur_q <= cur_d;
      user_valid_q <= user_valid_d;
      score_q <= score_d;
      start_prev_q <= start_prev_d;
      new_record_q <= new_record_d;
      best_overall_q <= best_overall_d;
      best_overall_user_q <= best_overall_user_d;
      tick_q <= tick_d;
      blink_q <= blink_d;
      led_q <= led_d;
    end
  end
  assign busy = (state_q == S_LOOKUP) || (state_q == S_UPDATE);
  assign best_user_score = user_valid_q ? slot_best[cur_q] : '0;
  assign best_overall = best_overall_q;
  assign best_overall_user = best_overall_user_q;
  assign new_record = new_record_q;
  assign record_led = led_q;
  assign disp_sel = (state_q == S_SHOW);
endmodule

// File: tb/tb_high_score_keeper.sv
// tb_high_score_keeper: scoreboard bench checking lookup/alloc/evict, updates, show timing and reset
module tb_high_score_keeper;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic user_load = 1'b0;
  logic [3:0] user_id = '0;
  logic game_start = 1'b0;
  logic game_stop = 1'b0;
  logic [6:0] score = '0;
  logic tick_100ms = 1'b0;
  logic busy, new_record, record_led, disp_sel;
  logic [6:0] best_user_score, best_overall;
  logic [3:0] best_overall_user;
  typedef struct {
    logic [6:0] bus;
    logic [6:0] bo;
    logic [3:0] bou;
    logic nr;
  } exp_t;
  exp_t sb[$];
  string sb_name[$];
  exp_t mon_e;
  string mon_n;
  logic busy_prev = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  high_score_keeper dut (
    .clk(clk),
    .rst(rst),
    .user_load(user_load),
    .user_id(user_id),
    .game_start(game_start),
    .game_stop(game_stop),
    .score(score),
    .tick_100ms(tick_100ms),
    .busy(busy),
    .best_user_score(best_user_score),
    .best_overall(best_overall),
    .best_overall_user(best_overall_user),
    .new_record(new_record),
    .record_led(record_led),
    .disp_sel(disp_sel)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic expect_out(input string n, input int bus, input int bo, input int bou, input bit nr);
    exp_t e;
    e.bus = 7'(bus);
    e.bo = 7'(bo);
    e.bou = 4'(bou);
    e.nr = nr;
    sb.push_back(e);
    sb_name.push_back(n);
  endtask
  always @(negedge clk) begin
    if (busy_prev === 1'b1 && busy === 1'b0) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        mon_n = sb_name.pop_front();
        chk({mon_n, "_bus"}, 32'(best_user_score), 32'(mon_e.bus));
        chk({mon_n, "_bo"}, 32'(best_overall), 32'(mon_e.bo));
        chk({mon_n, "_bou"}, 32'(best_overall_user), 32'(mon_e.bou));
        chk({mon_n, "_nr"}, 32'(new_record), 32'(mon_e.nr));
      end
    end
    busy_prev = busy;
  end
  task automatic login(input string n, input int id, input int lat, input int bus, input int bo, input int bou, input bit nr);
    int cyc;
    user_id = 4'(id);
    user_load = 1'b1;
    expect_out(n, bus, bo, bou, nr);
    @(posedge clk);
    #1 user_load = 1'b0;
    cyc = 1;
    while (busy && cyc < 20) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk({n, "_lat"}, 32'(cyc), 32'(lat));
  endtask
  task automatic play(input string n, input int s, input int bus, input int bo, input int bou, input bit nr);
    game_start = 1'b1;
    @(posedge clk);
    #1 expect_out(n, bus, bo, bou, nr);
    score = 7'(s);
    game_stop = 1'b1;
    game_start = 1'b0;
    @(posedge clk);
    #1 game_stop = 1'b0;
    @(posedge clk);
    #1;
  endtask
  task automatic show_run(input string n, input bit nr);
    chk({n, "_disp_t0"}, 32'(disp_sel), 1);
    chk({n, "_led_t0"}, 32'(record_led), 0);
    for (int t = 1; t <= 30; t++) begin
      tick_100ms = 1'b1;
      @(posedge clk);
      #1 tick_100ms = 1'b0;
      chk($sformatf("%s_disp_t%0d", n, t), 32'(disp_sel), 32'(t < 30));
      chk($sformatf("%s_led_t%0d", n, t), 32'(record_led), (nr && t < 30) ? 32'((t / 5) % 2) : 0);
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk_zero(input string n);
    chk({n, "_bus"}, 32'(best_user_score), 0);
    chk({n, "_bo"}, 32'(best_overall), 0);
    chk({n, "_bou"}, 32'(best_overall_user), 0);
    chk({n, "_nr"}, 32'(new_record), 0);
    chk({n, "_led"}, 32'(record_led), 0);
    chk({n, "_disp"}, 32'(disp_sel), 0);
    chk({n, "_busy"}, 32'(busy), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_zero("reset");
    login("t1_alloc", 3, 6, 0, 0, 0, 0);
    play("t2_game42", 42, 42, 42, 3, 1);
    show_run("t2_show", 1);
    chk("t2_ready_bus", 32'(best_user_score), 42);
    play("t3_tie42", 42, 42, 42, 3, 0);
    play("t3_low17", 17, 42, 42, 3, 0);
    show_run("t3_show", 0);
    chk("t3_ready_bus", 32'(best_user_score), 42);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    login("t4_id1", 1, 6, 0, 0, 0, 0);
    play("t4_p10", 10, 10, 10, 1, 1);
    login("t4_id2", 2, 6, 0, 10, 1, 1);
    play("t4_p5", 5, 5, 10, 1, 1);
    login("t4_id4", 4, 6, 0, 10, 1, 1);
    play("t4_p0", 0, 0, 10, 1, 0);
    login("t4_id5", 5, 6, 0, 10, 1, 0);
    play("t4_p42", 42, 42, 42, 5, 1);
    login("t4_id6_evict", 6, 6, 0, 42, 5, 1);
    login("t4_id4_miss", 4, 6, 0, 42, 5, 1);
    login("t4_id2_hit", 2, 3, 5, 42, 5, 1);
    login("t4_id1_hit", 1, 2, 10, 42, 5, 1);
    login("t4_id5_hit", 5, 5, 42, 42, 5, 1);
    game_start = 1'b1;
    @(posedge clk);
    #1 user_id = 4'd1;
    user_load = 1'b1;
    @(posedge clk);
    #1 user_load = 1'b0;
    chk("t5_load_ignored_busy", 32'(busy), 0);
    chk("t5_nr_cleared", 32'(new_record), 0);
    score = 7'd99;
    game_start = 1'b0;
    @(posedge clk);
    #1 chk("t5_abort_disp", 32'(disp_sel), 0);
    chk("t5_abort_busy", 32'(busy), 0);
    chk("t5_abort_bus", 32'(best_user_score), 42);
    login("t5_relogin", 5, 5, 42, 42, 5, 0);
    play("t6_p60", 60, 60, 60, 5, 1);
    repeat (3) begin
      tick_100ms = 1'b1;
      @(posedge clk);
      #1 tick_100ms = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk_zero("t6_show_rst");
    login("t6_miss", 5, 6, 0, 0, 0, 0);
    user_id = 4'd5;
    user_load = 1'b1;
    @(posedge clk);
    #1 user_load = 1'b0;
    expect_out("t6_lookup_rst", 0, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk_zero("t6_lookup_rst");
    login("t6_after", 5, 6, 0, 0, 0, 0);
    repeat (4) @(posedge clk);
    #1 chk("sb_drain", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
